// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver with double-buffered BCD capture and anti-ghosting blank.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 never blanked).
module seg7_scan_driver #(
    parameter int   DIGITS    = 4,
    parameter int   SCAN_DIV  = 50000,
    parameter int   BLANK_CYC = 2,
    parameter logic SEG_POL   = 1'b1,
    parameter logic AN_POL    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = {7{~SEG_POL}};
    localparam logic              DP_OFF   = ~SEG_POL;
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{~AN_POL}};

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal codes are dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    // Bit k set when digit k and every more significant digit are zero; bit 0 always clear.
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [4*DIGITS-1:0] word);
        logic [DIGITS-1:0] mask;
        logic              zero_above;
        mask       = {DIGITS{1'b0}};
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above & (word[4*k +: 4] == 4'd0);
            mask[k]    = zero_above;
        end
        return mask;
    endfunction

    logic [DIV_W-1:0]    div_r;
    logic [IDX_W-1:0]    idx_r;
    logic [4*DIGITS-1:0] pend_bcd_r;
    logic [DIGITS-1:0]   pend_dp_r;
    logic                pend_valid_r;
    logic [4*DIGITS-1:0] disp_bcd_r;
    logic [DIGITS-1:0]   disp_dp_r;
    logic [6:0]          seg_r;
    logic                dp_r;
    logic [DIGITS-1:0]   an_r;
    logic                frame_done_r;

    logic                slot_end_s;
    logic                wrap_s;
    logic                lit_s;
    logic [3:0]          digit_code_s;
    logic [DIGITS-1:0]   blank_mask_s;
    logic [6:0]          seg_next_s;
    logic                dp_next_s;
    logic [DIGITS-1:0]   an_next_s;

    assign slot_end_s   = (div_r == DIV_LAST);
    assign wrap_s       = enable && slot_end_s && (idx_r == IDX_LAST);
    assign lit_s        = (int'(div_r) >= BLANK_CYC);
    assign digit_code_s = disp_bcd_r[4*int'(idx_r) +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_mask_s = lead_zero_mask(disp_bcd_r);
`else
    assign blank_mask_s = {DIGITS{1'b0}};
`endif

    // Next value of the registered pin drivers from the current scan state.
    always_comb begin
        seg_next_s = SEG_OFF;
        dp_next_s  = DP_OFF;
        an_next_s  = AN_OFF;
        if (enable && lit_s) begin
            if (blank_mask_s[idx_r]) begin
                seg_next_s = SEG_OFF;
            end else begin
                seg_next_s = bcd_to_seg(digit_code_s) ^ SEG_OFF;
            end
            dp_next_s = disp_dp_r[idx_r] ^ DP_OFF;
            an_next_s = (DIGITS'(1) << idx_r) ^ AN_OFF;
        end else begin
            seg_next_s = SEG_OFF;
            dp_next_s  = DP_OFF;
            an_next_s  = AN_OFF;
        end
    end

    // Slot divider and digit index; both freeze while scanning is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r <= {DIV_W{1'b0}};
            idx_r <= {IDX_W{1'b0}};
        end else if (enable) begin
            if (slot_end_s) begin
                div_r <= {DIV_W{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IDX_W{1'b0}};
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end else begin
                div_r <= div_r + DIV_W'(1);
            end
        end else begin
            div_r <= div_r;
            idx_r <= idx_r;
        end
    end

    // Pending/display double buffer; a load on the wrap edge bypasses pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_bcd_r   <= {(4*DIGITS){1'b0}};
            pend_dp_r    <= {DIGITS{1'b0}};
            pend_valid_r <= 1'b0;
            disp_bcd_r   <= {(4*DIGITS){1'b0}};
            disp_dp_r    <= {DIGITS{1'b0}};
        end else if (wrap_s) begin
            pend_valid_r <= 1'b0;
            if (load) begin
                disp_bcd_r <= bcd_in;
                disp_dp_r  <= dp_in;
            end else if (pend_valid_r) begin
                disp_bcd_r <= pend_bcd_r;
                disp_dp_r  <= pend_dp_r;
            end else begin
                disp_bcd_r <= disp_bcd_r;
                disp_dp_r  <= disp_dp_r;
            end
        end else if (load) begin
            pend_bcd_r   <= bcd_in;
            pend_dp_r    <= dp_in;
            pend_valid_r <= 1'b1;
        end else begin
            pend_valid_r <= pend_valid_r;
        end
    end

    // Registered pin drivers and the frame-wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            an_r         <= AN_OFF;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_next_s;
            dp_r         <= dp_next_s;
            an_r         <= an_next_s;
            frame_done_r <= wrap_s;
        end
    end

    assign seg        = seg_r;
    assign dp         = dp_r;
    assign an         = an_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised and directed bench for seg7_scan_driver against a time-based reference model.
module tb_seg7_scan_driver;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 1;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .SEG_POL   (1'b1),
        .AN_POL    (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: enabled-clock count since reset, displayed word, latest pending load.
    logic [6:0]  pat_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    int          tick;
    logic [15:0] m_disp;
    logic [3:0]  m_dp;
    logic [19:0] pend_q [$];

    function automatic logic [6:0] ref_seg(input int k);
        int  val;
        bit  blank;
        val   = int'((m_disp >> (4 * k)) & 16'h000F);
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (k > 0) && ((m_disp >> (4 * k)) == 16'h0000);
`endif
        if (blank || val > 9) return 7'h00;
        return pat_tbl[val];
    endfunction

    task automatic model_reset();
        tick   = 0;
        m_disp = 16'h0000;
        m_dp   = 4'h0;
        pend_q.delete();
    endtask

    // Drive one cycle from a negedge, predict, then compare at the following negedge.
    task automatic step(input logic en, input logic ld, input logic [15:0] b, input logic [3:0] d);
        int         pos;
        int         dig;
        bit         wrap;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        enable = en;
        load   = ld;
        bcd_in = b;
        dp_in  = d;
        pos  = tick % SCAN_DIV;
        dig  = (tick / SCAN_DIV) % DIGITS;
        wrap = en && (pos == SCAN_DIV - 1) && (dig == DIGITS - 1);
        if (en && pos >= BLANK_CYC) begin
            e_seg = ref_seg(dig);
            e_dp  = m_dp[dig];
            e_an  = ~(4'b0001 << dig);
        end else begin
            e_seg = 7'h00;
            e_dp  = 1'b0;
            e_an  = 4'b1111;
        end
        if (wrap) begin
            if (ld) begin
                m_disp = b;
                m_dp   = d;
                pend_q.delete();
            end else if (pend_q.size() > 0) begin
                {m_dp, m_disp} = pend_q.pop_front();
            end
        end else if (ld) begin
            pend_q.delete();
            pend_q.push_back({d, b});
        end
        if (en) tick++;
        @(negedge clk);
        check_val("seg", {25'd0, seg}, {25'd0, e_seg});
        check_val("dp", {31'd0, dp}, {31'd0, e_dp});
        check_val("an", {28'd0, an}, {28'd0, e_an});
        check_val("frame_done", {31'd0, frame_done}, {31'd0, wrap});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, bcd_in, dp_in);
    endtask

    task automatic run_to_wrap();
        int guard;
        guard = 0;
        while ((tick % FRAME) != FRAME - 1 && guard < FRAME) begin
            step(1'b1, 1'b0, bcd_in, dp_in);
            guard++;
        end
    endtask

    // Asynchronous reset mid-slot, outputs must go inactive before the next clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_val("rst_seg", {25'd0, seg}, 32'h0000_0000);
        check_val("rst_dp", {31'd0, dp}, 32'h0000_0000);
        check_val("rst_an", {28'd0, an}, 32'h0000_000F);
        check_val("rst_fd", {31'd0, frame_done}, 32'h0000_0000);
        @(negedge clk);
        check_val("rst_hold_an", {28'd0, an}, 32'h0000_000F);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        load   = 1'b0;
        bcd_in = 16'h0000;
        dp_in  = 4'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("init_seg", {25'd0, seg}, 32'h0000_0000);
        check_val("init_an", {28'd0, an}, 32'h0000_000F);
        rst = 1'b0;

        // Zero display first, then scan order of 1234.
        run(3);
        check_val("first_digit0", {25'd0, seg}, 32'h0000_003F);
        step(1'b1, 1'b1, 16'h1234, 4'b0000);
        run_to_wrap();
        step(1'b1, 1'b0, bcd_in, dp_in);
        run(FRAME);

        // Double buffering with an overwrite before the wrap.
        run(6);
        step(1'b1, 1'b1, 16'h5678, 4'b0000);
        run(3);
        step(1'b1, 1'b1, 16'h9999, 4'b0001);
        run_to_wrap();
        step(1'b1, 1'b0, bcd_in, dp_in);
        run(FRAME);

        // Load exactly on the wrap edge.
        run_to_wrap();
        step(1'b1, 1'b1, 16'h0042, 4'b0100);
        run(FRAME);

        // Scanning paused mid-slot, with a load captured while paused.
        run(5);
        for (int i = 0; i < 4; i++) step(1'b0, (i == 2), 16'h0817, 4'b1000);
        run(2 * FRAME);

        // Invalid code in digit 2 with its decimal point set.
        step(1'b1, 1'b1, 16'h3A21, 4'b0100);
        run(2 * FRAME);

        // Reset in the middle of a slot with a pending load outstanding.
        run(6);
        step(1'b1, 1'b1, 16'h7777, 4'b1111);
        do_reset();
        run(FRAME + 2);

        // Random traffic.
        for (int i = 0; i < 900; i++) begin
            step(($urandom_range(0, 7) != 0), ($urandom_range(0, 11) == 0),
                 16'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
